// File: rtl/ram_bus_ctrl.sv
// Single-port data RAM behind valid/ready request/response channels with byte strobes,
// wait states and error reporting. Define RAM_BUS_STATS_EN to add response counters.
`timescale 1ns/1ps
module ram_bus_ctrl #(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DEPTH       = 4096,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
`ifdef RAM_BUS_STATS_EN
    ,
    output logic [31:0]         stat_rd,
    output logic [31:0]         stat_wr,
    output logic [31:0]         stat_err
`endif
);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned OFF_W    = $clog2(STRB_W);
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                err_q, err_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0]   req_off, req_word;
    logic                req_bad;
    logic                acc_we, acc_err, enter_resp, mem_we;
    logic [IDX_W-1:0]    acc_idx;
    logic [DATA_W-1:0]   acc_wdata;
    logic [STRB_W-1:0]   acc_wstrb;

    // Addresses below BASE_ADDR wrap to huge indices and land in the out-of-range check.
    always_comb begin
        req_off  = req_addr - BASE_ADDR;
        req_word = req_off >> OFF_W;
        req_bad  = (|(req_addr & ADDR_W'(STRB_W - 1))) || (req_word >= ADDR_W'(DEPTH));
    end

    // With no wait states the access happens on the accept edge, straight from the inputs.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we;
            acc_err   = req_bad;
            acc_idx   = req_word[IDX_W-1:0];
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_we    = we_q;
            acc_err   = err_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        err_d       = err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_word[IDX_W-1:0];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    err_d   = req_bad;
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(CNT_INIT);
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (enter_resp) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? '0 : mem_q[acc_idx];
        end
        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        mem_we      = enter_resp && acc_we && !acc_err && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Contents survive rst on purpose.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (acc_wstrb[k]) mem_q[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef RAM_BUS_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d, stat_err_q, stat_err_d;

    always_comb begin
        stat_rd_d  = stat_rd_q;
        stat_wr_d  = stat_wr_q;
        stat_err_d = stat_err_q;
        if (rsp_valid_q && rsp_ready) begin
            if (rsp_err_q) begin
                if (stat_err_q != '1) stat_err_d = stat_err_q + 32'd1;
            end else if (we_q) begin
                if (stat_wr_q != '1) stat_wr_d = stat_wr_q + 32'd1;
            end else begin
                if (stat_rd_q != '1) stat_rd_d = stat_rd_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_rd_q  <= stat_rd_d;
            stat_wr_q  <= stat_wr_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`endif
endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Scoreboard bench for ram_bus_ctrl: one instance with no wait states and one with three,
// driven by directed and random accesses against an array model of the RAM.
`timescale 1ns/1ps
module tb_ram_bus_ctrl;
    localparam int NP    = 2;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } exp_t;

    logic              clk = 1'b0;
    logic [NP-1:0]     rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       req_addr  [NP];
    logic [31:0]       req_wdata [NP];
    logic [3:0]        req_wstrb [NP];
    logic [31:0]       rsp_rdata [NP];
    logic [31:0]       stat_rd [NP], stat_wr [NP], stat_err [NP];

    exp_t              sbq [NP][$];
    logic [31:0]       model [NP][DEPTH];
    int                exp_rd [NP], exp_wr [NP], exp_er [NP];
    int                nvec = 0, nmis = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NP; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 0 : 3;
        ram_bus_ctrl #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .DEPTH       (DEPTH),
            .BASE_ADDR   (32'h0),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
`ifdef RAM_BUS_STATS_EN
            ,
            .stat_rd   (stat_rd[g]),
            .stat_wr   (stat_wr[g]),
            .stat_err  (stat_err[g])
`endif
        );

        exp_t e;
        // Monitor: a response is consumed on the edge after a negedge with valid & ready.
        always @(negedge clk) begin
            if (!rst[g] && rsp_valid[g] && rsp_ready[g]) begin
                if (sbq[g].size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_rsp port %0d: got response, want none", g);
                end else begin
                    e = sbq[g].pop_front();
                    check("sb_rdata", g, rsp_rdata[g], e.rdata);
                    check("sb_err", g, 32'(rsp_err[g]), 32'(e.err));
                    if (e.err) exp_er[g]++;
                    else if (e.we) exp_wr[g]++;
                    else exp_rd[g]++;
                end
            end
        end
    end

    task automatic check(input string name, input int p, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s port %0d: got %08h want %08h", name, p, act, exp);
        end
    endtask

    function automatic int wait_of(input int p);
        return (p == 0) ? 0 : 3;
    endfunction

    task automatic access(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold);
        exp_t        e;
        logic [31:0] idx, w;
        int          k;
        idx     = addr >> 2;
        e.we    = we;
        e.err   = (addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
        e.rdata = '0;
        if (!e.err) begin
            w = model[p][idx[11:0]];
            if (we) begin
                for (int l = 0; l < 4; l++) if (strb[l]) w[8*l +: 8] = wdata[8*l +: 8];
                model[p][idx[11:0]] = w;
            end else begin
                e.rdata = w;
            end
        end
        k = 0;
        while (!req_ready[p] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_ready_idle", p, 32'(req_ready[p]), 32'd1);
        sbq[p].push_back(e);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_wstrb[p] = strb;
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        req_addr[p]  = $urandom;
        k = 0;
        while (!rsp_valid[p] && k < 40) begin
            check("req_ready_busy", p, 32'(req_ready[p]), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        if (!rsp_valid[p]) begin
            nvec++;
            nmis++;
            $display("FAIL rsp_timeout port %0d: got no rsp_valid, want one", p);
            void'(sbq[p].pop_back());
            return;
        end
        check("latency", p, 32'(k + 1), 32'(wait_of(p) + 1));
        for (int i = 0; i < hold; i++) begin
            check("hold_rdata", p, rsp_rdata[p], e.rdata);
            check("hold_err", p, 32'(rsp_err[p]), 32'(e.err));
            check("hold_req_ready", p, 32'(req_ready[p]), 32'd0);
            check("hold_valid", p, 32'(rsp_valid[p]), 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready[p] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[p] = 1'b0;
        check("done_valid", p, 32'(rsp_valid[p]), 32'd0);
        check("done_req_ready", p, 32'(req_ready[p]), 32'd1);
        check("done_rdata_kept", p, rsp_rdata[p], e.rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < DEPTH; i++) model[p][i] = '0;
            req_addr[p]  = '0;
            req_wdata[p] = '0;
            req_wstrb[p] = '0;
            exp_rd[p] = 0;
            exp_wr[p] = 0;
            exp_er[p] = 0;
        end
        rst = '1;
        req_valid = '0;
        req_we = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = '0;
        for (int p = 0; p < NP; p++) begin
            check("rst_req_ready", p, 32'(req_ready[p]), 32'd1);
            check("rst_rsp_valid", p, 32'(rsp_valid[p]), 32'd0);
            check("rst_rdata", p, rsp_rdata[p], 32'd0);
            check("rst_err", p, 32'(rsp_err[p]), 32'd0);
        end

        // Directed sequence, no wait states.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        access(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        access(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
        access(0, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF, 0);
        access(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        access(0, 1'b1, 32'h14, 32'h5555AAAA, 4'h0, 0);
        access(0, 1'b0, 32'h14, 32'h0, 4'h0, 0);

        // Three wait states, response held off for five cycles.
        access(1, 1'b1, 32'h10, 32'hA5A5_0F0F, 4'hF, 0);
        access(1, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        access(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 2);

        // Reset during WAIT drops the write.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h12345678;
        req_wstrb[1] = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        exp_rd[1] = 0;
        exp_wr[1] = 0;
        exp_er[1] = 0;
        for (int i = 0; i < 6; i++) begin
            check("rstwait_valid", 1, 32'(rsp_valid[1]), 32'd0);
            check("rstwait_req_ready", 1, 32'(req_ready[1]), 32'd1);
            @(posedge clk); #1;
        end
        access(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Random mix of aligned, misaligned and out-of-range accesses.
        for (int p = 0; p < NP; p++) begin
            for (int n = 0; n < 60; n++) begin
                int unsigned kind;
                logic [31:0] a;
                kind = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 63)) << 2;
                if (kind == 0) a = a | 32'($urandom_range(1, 3));
                else if (kind == 1) a = 32'h0000_4000 | ($urandom & 32'h7FFF_FFFC);
                access(p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            check("sb_drain", p, 32'(sbq[p].size()), 32'd0);
`ifdef RAM_BUS_STATS_EN
            check("stat_rd", p, stat_rd[p], 32'(exp_rd[p]));
            check("stat_wr", p, stat_wr[p], 32'(exp_wr[p]));
            check("stat_err", p, stat_err[p], 32'(exp_er[p]));
`endif
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/ram_bus_ctrl.md
Name: ram_bus_ctrl

Overview:
- Parametrised single-port data RAM with valid/ready request and response channels, per-byte write strobes and configurable wait states.
- Successor to the fixed 32-bit, always-ready RAM. Adds address-range and alignment error reporting and a handshake-driven write/read completion.
- Sits on the core's data memory bus. The LSU issues one request at a time and consumes one response per request.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, power of two.
- ADDR_W, 32, byte-address width.
- DEPTH, 4096, number of DATA_W-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 0, extra cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte-lane write enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  access error flag.

Behaviour:
- Reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM goes to IDLE and the wait counter goes to 0. Memory contents are not cleared by rst; they are zero-initialised at time 0 only.
- Word index = (req_addr - BASE_ADDR) >> log2(DATA_W/8), computed in ADDR_W-bit unsigned arithmetic with wrap.
- Misaligned = any of the low log2(DATA_W/8) address bits set.
- Out of range = index >= DEPTH, including addresses below BASE_ADDR, which wrap to a large index.
- States are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: capture request.
  - Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At 0, go to RESP on the next edge.
- Entry into RESP (the same edge for both reads and writes):
  - Read: rsp_rdata latched from memory.
  - Write: the memory update is applied for each lane with wstrb=1 (lane k = bits 8k+7:8k). rsp_rdata=0.
  - Error (misaligned or out of range): no memory update, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: go to IDLE, rsp_valid=0.
  - rsp_rdata and rsp_err keep their last values.
- Latency: request accept edge to rsp_valid = 1 + WAIT_CYCLES cycles.
- Maximum throughput is one access per 2 + WAIT_CYCLES cycles.
- Write with wstrb=0: legal, no memory change, rsp_err=0.
- Read following a write to the same address returns the written data; no forwarding path is needed.
- rst asserted in WAIT or RESP: pending access is dropped and no response is produced.
  - A write dropped in WAIT is not applied.
  - A write already applied on RESP entry stays applied.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: RAM_BUS_STATS_EN.
- When defined:
  - Extra outputs stat_rd (32), stat_wr (32) and stat_err (32).
  - Each counts completed responses (rsp_valid & rsp_ready) of that kind; error responses count only in stat_err.
  - Counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=0:
  - Write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, rsp_ready=1 -> rsp_valid exactly 1 cycle after accept, rsp_err=0.
  - Then read 0x10 -> rsp_rdata=0xDEADBEEF.
- Partial write to 0x10, wdata 0x000000AA, wstrb 4'b0001 over 0xDEADBEEF -> read returns 0xDEADBEAA.
- Misaligned read 0x13 -> rsp_err=1, rsp_rdata=0.
- Write to index DEPTH (addr 0x4000 with defaults) -> rsp_err=1; a subsequent read of 0x0 is unchanged.
- WAIT_CYCLES=3, read with rsp_ready held 0 for 5 cycles:
  - rsp_valid rises 4 cycles after accept; rdata is stable and req_ready=0 throughout.
  - Completes on the rsp_ready cycle; req_ready=1 on the next cycle.
- rst pulsed during WAIT of a write to 0x20 (wdata 0x12345678):
  - rsp_valid stays 0, req_ready=1 after reset.
  - Reading 0x20 returns its prior value.
- RAM_BUS_STATS_EN defined: 2 reads, 1 write, 1 misaligned access -> stat_rd=2, stat_wr=1, stat_err=1.
